// File: rtl/conv_window_scheduler.sv
// Sliding-window scheduler: walks a KxK window over an input map, issues window
// reads, hands each window to the compute engine and writes results back densely.
//
// state   | meaning
// IDLE    | waiting for start; rejects maps smaller than the window
// READ    | window read request outstanding (enable=1, write=0)
// FEED    | window held in memory output registers for the compute engine
// WRITE   | result write request outstanding (enable=1, write=1)
// RELEASE | one-cycle enable gap; advance window position
// DONE    | one-cycle completion pulse
module conv_window_scheduler #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int K      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] img_w,
  input  logic [ADDR_W-1:0] img_h,
  input  logic [ADDR_W-1:0] out_base,
  output logic              enable,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [ADDR_W-1:0] offset,
  output logic [DATA_W-1:0] input_data,
  input  logic              finish,
  output logic              win_valid,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    FEED    = 3'd2,
    WRITE   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] K_A = ADDR_W'(K);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] img_w_q, img_h_q, out_base_q;
  logic [ADDR_W-1:0] row_q, col_q, out_idx_q, row_addr_q;
  logic              error_q;
  logic              bad_dims, last_col, last_row, last_win;

  assign bad_dims = (img_w < K_A) || (img_h < K_A);
  assign last_col = (col_q == img_w_q - K_A);
  assign last_row = (row_q == img_h_q - K_A);
  assign last_win = last_col && last_row;
  assign error    = error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    enable    = 1'b0;
    write     = 1'b0;
    win_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && !bad_dims) state_d = READ;
      end
      READ: begin
        enable = 1'b1;
        if (finish) state_d = FEED;
      end
      FEED: begin
        win_valid = 1'b1;
        if (res_valid) state_d = WRITE;
      end
      WRITE: begin
        enable = 1'b1;
        write  = 1'b1;
        if (finish) state_d = RELEASE;
      end
      RELEASE: state_d = last_win ? DONE : READ;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // row_addr_q tracks img_base + row*img_w so no multiplier is needed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      img_w_q    <= '0;
      img_h_q    <= '0;
      out_base_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      out_idx_q  <= '0;
      row_addr_q <= '0;
      address    <= '0;
      offset     <= '0;
      input_data <= '0;
      error_q    <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (bad_dims) begin
              error_q <= 1'b1;
            end else begin
              img_w_q    <= img_w;
              img_h_q    <= img_h;
              out_base_q <= out_base;
              row_q      <= '0;
              col_q      <= '0;
              out_idx_q  <= '0;
              row_addr_q <= img_base;
              address    <= img_base;
              offset     <= img_w;
            end
          end
        end
        FEED: begin
          if (res_valid) begin
            input_data <= res_data;
            address    <= out_base_q + out_idx_q;
          end
        end
        RELEASE: begin
          out_idx_q <= out_idx_q + ADDR_W'(1);
          if (last_col) begin
            col_q      <= '0;
            row_q      <= row_q + ADDR_W'(1);
            row_addr_q <= row_addr_q + img_w_q;
          end else begin
            col_q <= col_q + ADDR_W'(1);
          end
          // address keeps the final write address once the job completes
          if (!last_win) begin
            if (last_col) address <= row_addr_q + img_w_q;
            else          address <= row_addr_q + col_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler with a behavioural memory and
// compute engine whose response delays are adjustable per step.
module tb_conv_window_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] img_base = '0, img_w = '0, img_h = '0, out_base = '0;
  logic        enable, write, win_valid, busy, done, error;
  logic [15:0] address, offset, input_data;
  logic        finish = 1'b0;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = '0;

  int          checks = 0;
  int          errors = 0;
  int          fin_delay = 0;
  int          res_delay = 0;
  logic [15:0] res_xor = 16'hA000;
  int          fcnt = 0;
  int          rcnt = 0;

  conv_window_scheduler #(.ADDR_W(16), .DATA_W(16), .K(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .img_base(img_base), .img_w(img_w), .img_h(img_h), .out_base(out_base),
    .enable(enable), .write(write), .address(address), .offset(offset),
    .input_data(input_data), .finish(finish), .win_valid(win_valid),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // memory: raises finish fin_delay+1 edges after enable, clears when enable drops
  always @(posedge clk) begin
    if (!enable) begin
      finish <= 1'b0;
      fcnt   <= 0;
    end else if (!finish) begin
      if (fcnt >= fin_delay) finish <= 1'b1;
      else                   fcnt   <= fcnt + 1;
    end
  end

  // compute engine: one-cycle result pulse res_delay+1 edges after win_valid
  always @(posedge clk) begin
    if (win_valid && !res_valid) begin
      if (rcnt >= res_delay) begin
        res_valid <= 1'b1;
        res_data  <= res_xor ^ address;
      end else begin
        rcnt <= rcnt + 1;
      end
    end else begin
      res_valid <= 1'b0;
      rcnt      <= 0;
    end
  end

  logic        en_prev = 1'b0;
  int          nreq = 0;
  logic [15:0] log_addr [64];
  logic [15:0] log_off  [64];
  logic [15:0] log_dat  [64];
  logic        log_wr   [64];
  int          done_cnt = 0, rd_cyc = 0, fv_cyc = 0, wr_cyc = 0;

  always @(negedge clk) begin
    if (enable && !en_prev && nreq < 64) begin
      log_addr[nreq] = address;
      log_off[nreq]  = offset;
      log_dat[nreq]  = input_data;
      log_wr[nreq]   = write;
      nreq++;
    end
    en_prev = enable;
    if (done)              done_cnt++;
    if (enable && !write)  rd_cyc++;
    if (win_valid)         fv_cyc++;
    if (enable && write)   wr_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok, output int bad);
    ok  = 1'b0;
    bad = 0;
    for (int i = 0; i < max; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (!busy) bad++;
      @(negedge clk);
    end
  endtask

  // 6x6 map, 2x2 windows; optional start (with changed inputs) mid-job
  task automatic run_job6(input bit mid, input string nm);
    logic [15:0] ra [4];
    int b, d, bad, idx;
    bit ok;
    ra[0] = 16'h0100; ra[1] = 16'h0101; ra[2] = 16'h0106; ra[3] = 16'h0107;
    img_base = 16'h0100; img_w = 16'd6; img_h = 16'd6; out_base = 16'h0800;
    res_xor = 16'hA000; fin_delay = 0; res_delay = 0;
    b = nreq;
    d = done_cnt;
    pulse_start();
    chk({nm, "_start_busy"}, busy, 1);
    chk({nm, "_start_enable"}, enable, 1);
    chk({nm, "_first_addr"}, address, 16'h0100);
    chk({nm, "_first_offset"}, offset, 16'd6);
    ok  = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (!busy) bad++;
      if (mid && i == 5) begin
        start = 1'b1; img_base = 16'h0200; img_w = 16'd7; out_base = 16'h0900;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, ok, 1);
    chk({nm, "_busy_held"}, bad, 0);
    @(negedge clk);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_done_pulses"}, done_cnt - d, 1);
    chk({nm, "_req_count"}, nreq - b, 8);
    for (int k = 0; k < 4; k++) begin
      idx = b + 2 * k;
      chk({nm, "_rd_addr"}, log_addr[idx], ra[k]);
      chk({nm, "_rd_kind"}, log_wr[idx], 0);
      chk({nm, "_rd_offset"}, log_off[idx], 16'd6);
      chk({nm, "_wr_kind"}, log_wr[idx+1], 1);
      chk({nm, "_wr_addr"}, log_addr[idx+1], 16'h0800 + 16'(k));
      chk({nm, "_wr_data"}, log_dat[idx+1], 16'hA000 ^ ra[k]);
    end
  endtask

  initial begin
    int b, br, bad, wn, rc, fc, wc, d;
    bit ok, pw;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_enable", enable, 0);
    chk("rst_write", write, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_address", address, 0);
    chk("rst_offset", offset, 0);
    chk("rst_input_data", input_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // basic 6x6 job, then same job with an ignored mid-job start
    run_job6(1'b0, "job6");
    run_job6(1'b1, "midstart");

    // undersized map rejected
    img_base = 16'h0100; img_w = 16'd4; img_h = 16'd9; out_base = 16'h0800;
    b = nreq;
    pulse_start();
    chk("err_pulse", error, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_one_cycle", error, 0);
    repeat (5) @(negedge clk);
    chk("err_no_requests", nreq - b, 0);
    chk("err_idle", busy, 0);

    // single-window map
    img_base = 16'h0000; img_w = 16'd5; img_h = 16'd5; out_base = 16'h0400;
    res_xor = 16'h7FFF;
    b = nreq;
    d = done_cnt;
    pulse_start();
    wait_done(200, ok, bad);
    chk("one_done_seen", ok, 1);
    chk("one_busy_held", bad, 0);
    @(negedge clk);
    chk("one_req_count", nreq - b, 2);
    chk("one_rd_addr", log_addr[b], 16'h0000);
    chk("one_rd_kind", log_wr[b], 0);
    chk("one_rd_offset", log_off[b], 16'd5);
    chk("one_wr_addr", log_addr[b+1], 16'h0400);
    chk("one_wr_kind", log_wr[b+1], 1);
    chk("one_wr_data", log_dat[b+1], 16'h7FFF);
    chk("one_done_pulses", done_cnt - d, 1);

    // slow memory and slow compute engine
    img_base = 16'h0300; img_w = 16'd5; img_h = 16'd5; out_base = 16'h0500;
    res_xor = 16'h1234; fin_delay = 10; res_delay = 7;
    b = nreq; rc = rd_cyc; fc = fv_cyc; wc = wr_cyc;
    pulse_start();
    wait_done(300, ok, bad);
    chk("slow_done_seen", ok, 1);
    chk("slow_busy_held", bad, 0);
    @(negedge clk);
    chk("slow_req_count", nreq - b, 2);
    chk("slow_read_cycles", rd_cyc - rc, 12);
    chk("slow_feed_cycles", fv_cyc - fc, 9);
    chk("slow_write_cycles", wr_cyc - wc, 12);
    chk("slow_wr_data", log_dat[b+1], 16'h1234 ^ 16'h0300);
    fin_delay = 0; res_delay = 0;

    // reset during the write of window 2, then rerun from scratch
    img_base = 16'h0100; img_w = 16'd6; img_h = 16'd6; out_base = 16'h0800;
    res_xor = 16'hA000;
    pulse_start();
    wn = 0;
    pw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (enable && write && !pw) wn++;
      pw = enable && write;
      if (wn == 2) break;
      @(negedge clk);
    end
    chk("rst_mid_reached_write2", wn, 2);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_enable", enable, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_write", write, 0);
    chk("rst_mid_address", address, 0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    br = nreq;
    repeat (10) @(negedge clk);
    chk("rst_no_resume_busy", busy, 0);
    chk("rst_no_resume_reqs", nreq - br, 0);
    run_job6(1'b0, "rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
